lvds_link_arbiter: RTL and testbench
====================================

# lvds_link_arbiter

Round-robin arbiter and framer for the 4-bit inter-FPGA LVDS lane (`enq_serial`/`deq_serial` nibble path). It shares the single outbound lane between `NUM_REQ` 32-bit flit sources, such as NIOS put-port, echo path and diagnostics. Each granted flit is captured, then serialized as a header nibble followed by eight data nibbles. It sits between the flit producers and the serializer's `enq_serial` put method in the FPGA top level.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `FLIT_W`, default 32: flit width; fixed at 8 nibbles.
- `NIB_W`, default 4: lane width.

Ports:
- `CLK` in 1: single clock for the whole block.
- `RST_N` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: requester i has a flit pending.
- `req_flit` in `NUM_REQ*FLIT_W`: flit of requester i, at bits `[i*32 +: 32]`.
- `req_ready` out `NUM_REQ`: one-hot accept; a flit transfers when `req_valid[i]&req_ready[i]`.
- `link_data` out 4: nibble to the serializer put port.
- `link_valid` out 1: `link_data` holds a valid beat; drives `EN_enq_serial` gating.
- `link_ready` in 1: serializer can accept; this is `RDY_enq_serial AND` the peer's `IN_RDY`.
- `grant_id` out 3: index of the frame currently in flight.
- `busy` out 1: a frame is in flight (not IDLE).

## Operation
- States: `IDLE`, `HDR`, `DATA`, and `PAR` when parity is enabled.
- `IDLE`:
  - If any `req_valid` is set, select the first set bit at or after `rr_ptr`, wrapping modulo `NUM_REQ`.
  - Assert `req_ready[winner]` combinationally in the same cycle.
  - Load the flit into the shift register, set `grant_id` to the winner, and set `rr_ptr` to `(winner+1) mod NUM_REQ`.
  - Go to `HDR`.
- `HDR`: `link_data = {1'b1, grant_id}`. On a handshake (`link_valid & link_ready`), go to `DATA` with `beat_cnt = 0`.
- `DATA`:
  - `link_data = shreg[31:28]`; transmission is MSB nibble first.
  - On each handshake: shift left by 4, increment `beat_cnt`.
  - On the handshake with `beat_cnt == 7`: go to `IDLE`, or to `PAR` if enabled.
- `PAR`: `link_data` = XOR of the 8 data nibbles, accumulated as they are sent. On a handshake, go to `IDLE`.
- Handshake rules:
  - `link_valid` is high exactly in `HDR`, `DATA` and `PAR`.
  - Once `link_valid` is asserted, it and `link_data` stay stable until `link_ready` is seen. There is no retraction.
  - `link_ready` is ignored in `IDLE`.
- `req_ready` is zero outside `IDLE`. A requester that drops `req_valid` before it is granted is simply skipped.
- When no `req_valid` bit is set in `IDLE`, `rr_ptr` is unchanged.
- Reset mid-frame aborts the frame immediately (asynchronous). The receiver resynchronizes on the MSB=1 header marker; data nibbles carry no framing meaning.

## Timing
- Reset values: state `IDLE`, `link_valid` 0, `link_data` 0, `req_ready` 0, `grant_id` 0, `busy` 0, `rr_ptr` 0, `beat_cnt` 0, parity accumulator 0.
- Latency: a request granted in cycle T produces the header on `link_valid` in cycle T+1.
- Throughput with `link_ready` held high:
  - 10 cycles per frame (1 `IDLE` grant cycle + 1 header + 8 data).
  - 11 cycles per frame with parity.
- Each `link_ready` low cycle stalls the current beat by one cycle.
- `busy` and `grant_id` are registered and change only on state transitions.

## Configuration
- Macro `LVDS_LINK_PARITY_EN`.
- Defined: the `PAR` state is compiled in, and each frame is 10 nibbles with a trailing XOR parity nibble.
- Undefined: there is no `PAR` state and no accumulator, and each frame is 9 nibbles.
- Both ends of a link must use the same setting.

## Structure
- Shared package `lvds_link_pkg`:
  - State enum `link_st_t`.
  - Constants `NIB_PER_FLIT = 8` and `HDR_MARK = 1'b1`.
  - Function `hdr_nibble(id)`.
- Sub-module `rr_arbiter`: parameterized by `NUM_REQ`; inputs `req` and `ptr`; outputs a one-hot `grant` and the encoded `winner`. It is purely combinational, and the pointer register stays in the parent.
- The parent holds the FSM, shift register, beat counter and parity accumulator.

## Test plan
- Single requester: `req_valid = 4'b0001`, `req_flit[0] = 32'hDEADBEEF`, `link_ready = 1` → `link_data` sequence `8, D, E, A, D, B, E, E, F`; `busy` falls after the 9th beat.
- Round-robin fairness: all four requesters valid continuously → `grant_id` order `0, 1, 2, 3, 0`; the header nibbles are `8, 9, A, B, 8`.
- Backpressure: `link_ready` low for 3 cycles during data beat 4 → the same nibble is held stable for 4 cycles; the total frame takes 13 cycles.
- Pointer wrap and skip: `rr_ptr = 3` with requesters 1 and 3 valid → requester 3 wins, then requester 1 wins; requester 0 is never granted.
- Reset mid-frame: `RST_N` asserted low during data beat 5 → `link_valid` is 0 asynchronously; after release the block is in `IDLE` and the next grant starts at requester 0.
- With `LVDS_LINK_PARITY_EN` defined: flit `32'h12345678` → 10th nibble is `4'h8` (XOR of 1..8), and `busy` is high for 10 beats.

Source files
------------

// File: rtl/lvds_link_pkg.sv
// Shared types and constants for the LVDS lane arbiter/framer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Optional feature macro: LVDS_LINK_PARITY_EN adds the PAR state, which sends
// a trailing XOR parity nibble after the data nibbles.
package lvds_link_pkg;

    // Data nibbles per 32-bit flit, sent MSB nibble first.
    localparam int NIB_PER_FLIT = 8;

    // The MSB of the header nibble is the receiver's resync marker.
    localparam logic HDR_MARK = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
`ifdef LVDS_LINK_PARITY_EN
        ,
        PAR  = 2'd3
`endif
    } link_st_t;

    // Header nibble: marker bit followed by the 3-bit requester index.
    function automatic logic [3:0] hdr_nibble(input logic [2:0] id);
        return {HDR_MARK, id};
    endfunction

endpackage

// File: rtl/lvds_link_arbiter_rr.sv
// Round-robin grant selection: first set request at or after ptr, wrapping.
// Latency: purely combinational, no state.
// Backpressure: none; the parent decides when the grant is used.
//
// Ports:
//   req    - request vector, one bit per source
//   ptr    - search start index; the parent keeps it below NUM_REQ
//   grant  - one-hot winner, all zero when req is empty
//   winner - encoded index of the winner, 0 when req is empty
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [2:0]         winner
);

    logic found;
    int   idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        // Walk the requesters starting at ptr; the first hit wins.
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = 3'(idx);
            end
        end
    end

endmodule

// File: rtl/lvds_link_arbiter.sv
// Shares one 4-bit LVDS lane among NUM_REQ flit sources, framing each flit as a header nibble plus 8 data nibbles.
// Latency: a grant in cycle T puts the header on link_valid in T+1; 10 cycles/frame (11 with parity) with link_ready high.
// Backpressure: link_ready low holds link_valid/link_data stable; req_ready is only offered while IDLE.
//
// Ports:
//   CLK, RST_N                  - clock, asynchronous active-low reset
//   req_valid/req_flit/req_ready - per-source flit handshake, flit i at req_flit[i*32 +: 32]
//   link_data/link_valid/link_ready - nibble stream to the serializer put port
//   grant_id, busy              - index of the frame in flight, frame-in-flight flag
//
// Optional feature macro: LVDS_LINK_PARITY_EN appends an XOR parity nibble to each frame.
// Both ends of a link must agree on it.
// NUM_REQ must lie in 2..8 because grant_id and the header carry a 3-bit index.
module lvds_link_arbiter
    import lvds_link_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int FLIT_W  = 32,
    parameter int NIB_W   = 4
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*FLIT_W-1:0] req_flit,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NIB_W-1:0]          link_data,
    output logic                      link_valid,
    input  logic                      link_ready,
    output logic [2:0]                grant_id,
    output logic                      busy
);

    link_st_t            state;
    logic [2:0]          rr_ptr;
    logic [2:0]          beat_cnt;
    logic [FLIT_W-1:0]   shreg;
`ifdef LVDS_LINK_PARITY_EN
    logic [NIB_W-1:0]    par_acc;
`endif

    logic [NUM_REQ-1:0]  grant;
    logic [2:0]          winner;
    logic [2:0]          next_ptr;
    logic [FLIT_W-1:0]   sel_flit;
    logic [NIB_W-1:0]    cur_nib;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .grant  (grant),
        .winner (winner)
    );

    // The accept is combinational so the winning source sees it in the
    // same cycle the flit is captured; no accept is offered mid-frame.
    assign req_ready = (state == IDLE) ? grant : '0;

    assign sel_flit = req_flit[int'(winner)*FLIT_W +: FLIT_W];
    assign next_ptr = (int'(winner) == NUM_REQ - 1) ? 3'd0 : winner + 3'd1;
    assign cur_nib  = shreg[FLIT_W-1 -: NIB_W];

    // The lane value is a pure decode of registered state, so it cannot
    // change while a beat waits for link_ready.
    always_comb begin
        link_data = '0;
        case (state)
            HDR:     link_data = hdr_nibble(grant_id);
            DATA:    link_data = cur_nib;
`ifdef LVDS_LINK_PARITY_EN
            PAR:     link_data = par_acc;
`endif
            default: link_data = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            link_valid <= 1'b0;
            busy       <= 1'b0;
            grant_id   <= 3'd0;
            rr_ptr     <= 3'd0;
            beat_cnt   <= 3'd0;
            shreg      <= '0;
`ifdef LVDS_LINK_PARITY_EN
            par_acc    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // link_ready has no meaning here; only requests matter.
                    // With nothing pending the pointer is left where it is.
                    if (|req_valid) begin
                        shreg      <= sel_flit;
                        grant_id   <= winner;
                        rr_ptr     <= next_ptr;
                        beat_cnt   <= 3'd0;
                        link_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= HDR;
`ifdef LVDS_LINK_PARITY_EN
                        par_acc    <= '0;
`endif
                    end
                end

                HDR: begin
                    if (link_ready) begin
                        beat_cnt <= 3'd0;
                        state    <= DATA;
                    end
                end

                DATA: begin
                    if (link_ready) begin
                        shreg    <= {shreg[FLIT_W-NIB_W-1:0], {NIB_W{1'b0}}};
                        beat_cnt <= beat_cnt + 3'd1;
`ifdef LVDS_LINK_PARITY_EN
                        par_acc  <= par_acc ^ cur_nib;
`endif
                        if (beat_cnt == 3'(NIB_PER_FLIT - 1)) begin
`ifdef LVDS_LINK_PARITY_EN
                            state      <= PAR;
`else
                            state      <= IDLE;
                            link_valid <= 1'b0;
                            busy       <= 1'b0;
`endif
                        end
                    end
                end

`ifdef LVDS_LINK_PARITY_EN
                PAR: begin
                    if (link_ready) begin
                        state      <= IDLE;
                        link_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
`endif

                default: begin
                    state      <= IDLE;
                    link_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lvds_link_arbiter.sv
// Directed bench for lvds_link_arbiter: framing, round-robin order, stalls, reset abort.
// Latency: n/a (testbench).
// Backpressure: drives link_ready low for chosen beats.
module tb_lvds_link_arbiter;

    localparam int NUM_REQ = 4;
    localparam int FLIT_W  = 32;
`ifdef LVDS_LINK_PARITY_EN
    localparam int PAR_BEATS = 1;
`else
    localparam int PAR_BEATS = 0;
`endif

    localparam logic [31:0] F0 = 32'hDEADBEEF;
    localparam logic [31:0] F1 = 32'h12345678;
    localparam logic [31:0] F2 = 32'hCAFEF00D;
    localparam logic [31:0] F3 = 32'hA5C30F96;

    logic                      CLK = 1'b0;
    logic                      RST_N = 1'b0;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*FLIT_W-1:0] req_flit;
    logic [NUM_REQ-1:0]        req_ready;
    logic [3:0]                link_data;
    logic                      link_valid;
    logic                      link_ready;
    logic [2:0]                grant_id;
    logic                      busy;

    int vectors     = 0;
    int miscompares = 0;

    lvds_link_arbiter #(
        .NUM_REQ (NUM_REQ),
        .FLIT_W  (FLIT_W),
        .NIB_W   (4)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .req_valid  (req_valid),
        .req_flit   (req_flit),
        .req_ready  (req_ready),
        .link_data  (link_data),
        .link_valid (link_valid),
        .link_ready (link_ready),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // Entered in IDLE shortly after a clock edge with req_valid already set so
    // that requester 'id' wins at the next edge. Returns in IDLE after the frame.
    task automatic run_frame(input int id, input logic [31:0] flit,
                             input int stall_beat, input int stall_len);
        int         cycles;
        logic [3:0] nib;
        logic [3:0] par;
        cycles = 0;
        par    = 4'h0;
        #1;
        chk("grant_req_ready", 32'(req_ready), 32'(1 << id));
        chk("grant_link_valid", 32'(link_valid), 32'd0);
        tick(); cycles++;
        chk("hdr_link_valid", 32'(link_valid), 32'd1);
        chk("hdr_nibble", 32'(link_data), 32'(8 + id));
        chk("hdr_grant_id", 32'(grant_id), 32'(id));
        chk("hdr_busy", 32'(busy), 32'd1);
        chk("hdr_req_ready", 32'(req_ready), 32'd0);
        for (int b = 0; b < 8; b++) begin
            tick(); cycles++;
            nib = flit[31 - 4*b -: 4];
            par = par ^ nib;
            chk("data_nibble", 32'(link_data), 32'(nib));
            chk("data_link_valid", 32'(link_valid), 32'd1);
            if (b == stall_beat) begin
                link_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick(); cycles++;
                    chk("stall_hold_data", 32'(link_data), 32'(nib));
                    chk("stall_hold_valid", 32'(link_valid), 32'd1);
                end
                link_ready = 1'b1;
            end
        end
`ifdef LVDS_LINK_PARITY_EN
        tick(); cycles++;
        chk("par_nibble", 32'(link_data), 32'(par));
        chk("par_busy", 32'(busy), 32'd1);
`endif
        tick(); cycles++;
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_link_valid", 32'(link_valid), 32'd0);
        chk("end_link_data", 32'(link_data), 32'd0);
        chk("frame_cycles", 32'(cycles), 32'(10 + PAR_BEATS + stall_len));
    endtask

    initial begin
        req_valid  = '0;
        req_flit   = {F3, F2, F1, F0};
        link_ready = 1'b1;

        // Reset state.
        #3;
        chk("rst_link_valid", 32'(link_valid), 32'd0);
        chk("rst_link_data", 32'(link_data), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        RST_N = 1'b1;

        // Idle with no requests: link_ready toggling has no effect.
        link_ready = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_link_valid", 32'(link_valid), 32'd0);
        link_ready = 1'b1;
        tick();
        chk("idle_busy2", 32'(busy), 32'd0);

        // Single requester: 8,D,E,A,D,B,E,E,F.
        req_valid = 4'b0001;
        run_frame(0, F0, -1, 0);
        req_valid = 4'b0000;
        #1;
        chk("drop_req_ready", 32'(req_ready), 32'd0);

        // Backpressure on data beat 4; requester 1 idle, so 2 wins (ptr=1).
        req_valid = 4'b0100;
        run_frame(2, F2, 4, 3);
        req_valid = 4'b0000;

        // Pointer at 3, requesters 1 and 3: 3 wins, then wrap to 1.
        req_valid = 4'b1010;
        run_frame(3, F3, -1, 0);
        run_frame(1, F1, -1, 0);
        req_valid = 4'b0000;

        // Reset during data beat 5 of a frame from requester 2 (ptr=2).
        req_valid = 4'b0100;
        #1;
        chk("abort_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b0000;
        chk("abort_hdr", 32'(link_data), 32'hA);
        repeat (6) tick();
        chk("abort_beat5", 32'(link_data), 32'h0);
        chk("abort_beat5_valid", 32'(link_valid), 32'd1);
        #1;
        RST_N = 1'b0;
        #1;
        chk("abort_link_valid", 32'(link_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_link_data", 32'(link_data), 32'd0);
        chk("abort_grant_id", 32'(grant_id), 32'd0);
        tick();
        RST_N = 1'b1;

        // All four valid after reset: 0,1,2,3,0 back to back.
        req_valid = 4'b1111;
        run_frame(0, F0, -1, 0);
        run_frame(1, F1, -1, 0);
        run_frame(2, F2, -1, 0);
        run_frame(3, F3, -1, 0);
        run_frame(0, F0, -1, 0);
        req_valid = 4'b0000;
        tick();
        chk("final_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
